// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if: cache-to-memory request/acknowledge bus with cache (master) and memory (slave) views.
interface main_memory_responder_if #(
  parameter int address_space = 12,
  parameter int data_size = 32
);
  logic fetch;
  logic flush;
  logic [address_space-1:0] addra;
  logic [data_size-1:0] dina;
  logic [data_size-1:0] douta;
  logic fetch_ack;
  logic flush_ack;
  logic busy;
  modport master (output fetch, flush, addra, dina, input douta, fetch_ack, flush_ack, busy);
  modport slave (input fetch, flush, addra, dina, output douta, fetch_ack, flush_ack, busy);
endinterface

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency backing store serving cache fetch/flush requests with a four-phase handshake.
module main_memory_responder #(
  parameter int size = 4096,
  parameter int address_space = 12,
  parameter int data_size = 32,
  parameter int latency = 4
) (
  input logic clka,
  input logic rsta,
  main_memory_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, FETCH_WAIT = 2'd1, FLUSH_WAIT = 2'd2, ACK = 2'd3;
  localparam logic [7:0] lat_m1 = 8'(latency - 1);
  logic [1:0] state;
  logic [7:0] cnt;
  logic [address_space-1:0] addr_q;
  logic [data_size-1:0] data_q;
  logic [data_size-1:0] mem [size];
  logic wr_en;
  assign bus.busy = state != IDLE;
  // A reset in the final wait cycle suppresses the commit, so an aborted flush never lands.
  assign wr_en = !rsta && state == FLUSH_WAIT && cnt == 8'd0;
  always_ff @(posedge clka)
    if (wr_en) mem[addr_q] <= data_q;
  always_ff @(posedge clka) begin
    if (rsta) begin
      state <= IDLE;
      cnt <= '0;
      bus.douta <= '0;
      bus.fetch_ack <= 1'b0;
      bus.flush_ack <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.flush) begin
            addr_q <= bus.addra;
            data_q <= bus.dina;
            cnt <= lat_m1;
            state <= FLUSH_WAIT;
          end else if (bus.fetch) begin
            addr_q <= bus.addra;
            cnt <= lat_m1;
            state <= FETCH_WAIT;
          end
        FETCH_WAIT:
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            bus.douta <= mem[addr_q];
            bus.fetch_ack <= 1'b1;
            state <= ACK;
          end
        FLUSH_WAIT:
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            bus.flush_ack <= 1'b1;
            state <= ACK;
          end
        default:
          // Leaving ACK always returns to IDLE, so a still-pending request waits one more edge.
          if (bus.fetch_ack ? !bus.fetch : !bus.flush) begin
            bus.fetch_ack <= 1'b0;
            bus.flush_ack <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: vector table on a latency-4 instance plus a hand sequence on a latency-1 instance.
module tb_main_memory_responder;
  typedef struct {
    logic rst;
    logic fetch;
    logic flush;
    logic [11:0] addr;
    logic [31:0] din;
    logic exp_fa;
    logic exp_la;
    logic exp_busy;
    logic [31:0] exp_dout;
  } vec_t;
  logic clk = 1'b0;
  logic rst4, rst1;
  int total = 0, passed = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  main_memory_responder_if #(.address_space(12), .data_size(32)) bus4 ();
  main_memory_responder_if #(.address_space(12), .data_size(32)) bus1 ();
  main_memory_responder #(.size(4096), .address_space(12), .data_size(32), .latency(4)) dut4 (
    .clka(clk), .rsta(rst4), .bus(bus4.slave));
  main_memory_responder #(.size(4096), .address_space(12), .data_size(32), .latency(1)) dut1 (
    .clka(clk), .rsta(rst1), .bus(bus1.slave));
  task automatic add(input int n, input logic r, fe, fl, input logic [11:0] a, input logic [31:0] d,
                     input logic fa, la, bz, input logic [31:0] dout);
    vec_t v;
    v = '{r, fe, fl, a, d, fa, la, bz, dout};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask
  task automatic chk1(input string name, input logic fa, la, bz, input logic [31:0] dout);
    total++;
    if (bus1.fetch_ack === fa && bus1.flush_ack === la && bus1.busy === bz && bus1.douta === dout) passed++;
    else $display("FAIL %s: got fa=%b la=%b busy=%b dout=%h, want fa=%b la=%b busy=%b dout=%h",
                  name, bus1.fetch_ack, bus1.flush_ack, bus1.busy, bus1.douta, fa, la, bz, dout);
  endtask
  task automatic step1(input logic r, fe, fl, input logic [11:0] a, input logic [31:0] d);
    rst1 = r; bus1.fetch = fe; bus1.flush = fl; bus1.addra = a; bus1.dina = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst4 = 1'b1; bus4.fetch = 0; bus4.flush = 0; bus4.addra = 0; bus4.dina = 0;
    rst1 = 1'b1; bus1.fetch = 0; bus1.flush = 0; bus1.addra = 0; bus1.dina = 0;
    add(1, 1, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 1, 12'h123, 32'hDEADBEEF, 0, 0, 1, 32'h0);
    add(3, 0, 0, 1, 12'h7FF, 32'h0, 0, 0, 1, 32'h0);
    add(2, 0, 0, 1, 12'h7FF, 32'h0, 0, 1, 1, 32'h0);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h0);
    add(1, 0, 1, 0, 12'h123, 32'h0, 0, 0, 1, 32'h0);
    add(3, 0, 1, 0, 12'h000, 32'h0, 0, 0, 1, 32'h0);
    add(2, 0, 1, 0, 12'h000, 32'h0, 1, 0, 1, 32'hDEADBEEF);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'hDEADBEEF);
    add(4, 0, 1, 1, 12'h010, 32'h5, 0, 0, 1, 32'hDEADBEEF);
    add(1, 0, 1, 1, 12'h010, 32'h5, 0, 1, 1, 32'hDEADBEEF);
    add(1, 0, 1, 0, 12'h010, 32'h0, 0, 0, 0, 32'hDEADBEEF);
    add(4, 0, 1, 0, 12'h010, 32'h0, 0, 0, 1, 32'hDEADBEEF);
    add(1, 0, 1, 0, 12'h010, 32'h0, 1, 0, 1, 32'h5);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h5);
    add(4, 0, 0, 1, 12'h200, 32'hCAFE0000, 0, 0, 1, 32'h5);
    add(1, 0, 0, 1, 12'h200, 32'hCAFE0000, 0, 1, 1, 32'h5);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h5);
    add(2, 0, 0, 1, 12'h200, 32'h1, 0, 0, 1, 32'h5);
    add(1, 1, 0, 1, 12'h200, 32'h1, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h0);
    add(4, 0, 1, 0, 12'h200, 32'h0, 0, 0, 1, 32'h0);
    add(1, 0, 1, 0, 12'h200, 32'h0, 1, 0, 1, 32'hCAFE0000);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'hCAFE0000);
    add(4, 0, 0, 1, 12'h300, 32'hA5A5, 0, 0, 1, 32'hCAFE0000);
    add(1, 0, 0, 1, 12'h300, 32'hA5A5, 0, 1, 1, 32'hCAFE0000);
    add(1, 1, 0, 1, 12'h300, 32'hA5A5, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h0);
    add(4, 0, 1, 0, 12'h300, 32'h0, 0, 0, 1, 32'h0);
    add(1, 0, 1, 0, 12'h300, 32'h0, 1, 0, 1, 32'hA5A5);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'hA5A5);
    add(1, 0, 1, 0, 12'h123, 32'h0, 0, 0, 1, 32'hA5A5);
    add(3, 0, 0, 0, 12'h000, 32'h0, 0, 0, 1, 32'hA5A5);
    add(1, 0, 0, 0, 12'h000, 32'h0, 1, 0, 1, 32'hDEADBEEF);
    add(1, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'hDEADBEEF);
    foreach (vecs[i]) begin
      rst4 = vecs[i].rst; bus4.fetch = vecs[i].fetch; bus4.flush = vecs[i].flush;
      bus4.addra = vecs[i].addr; bus4.dina = vecs[i].din;
      @(posedge clk);
      #1;
      total++;
      if (bus4.fetch_ack === vecs[i].exp_fa && bus4.flush_ack === vecs[i].exp_la &&
          bus4.busy === vecs[i].exp_busy && bus4.douta === vecs[i].exp_dout) passed++;
      else $display("FAIL row%0d: got fa=%b la=%b busy=%b dout=%h, want fa=%b la=%b busy=%b dout=%h",
                    i, bus4.fetch_ack, bus4.flush_ack, bus4.busy, bus4.douta,
                    vecs[i].exp_fa, vecs[i].exp_la, vecs[i].exp_busy, vecs[i].exp_dout);
    end
    step1(1, 0, 0, 12'h000, 32'h0);
    chk1("l1_reset", 0, 0, 0, 32'h0);
    step1(0, 0, 1, 12'h005, 32'h77);
    chk1("l1_flush_accept", 0, 0, 1, 32'h0);
    step1(0, 0, 1, 12'h005, 32'h77);
    chk1("l1_flush_ack", 0, 1, 1, 32'h0);
    step1(0, 0, 0, 12'h000, 32'h0);
    chk1("l1_flush_drop", 0, 0, 0, 32'h0);
    step1(0, 0, 1, 12'h006, 32'h88);
    step1(0, 0, 1, 12'h006, 32'h88);
    chk1("l1_flush2_ack", 0, 1, 1, 32'h0);
    step1(0, 0, 0, 12'h000, 32'h0);
    step1(0, 1, 0, 12'h005, 32'h0);
    chk1("l1_fetch_accept", 0, 0, 1, 32'h0);
    step1(0, 1, 0, 12'h006, 32'h0);
    chk1("l1_fetch_captured", 1, 0, 1, 32'h77);
    step1(0, 1, 0, 12'h006, 32'h0);
    chk1("l1_fetch_hold", 1, 0, 1, 32'h77);
    step1(0, 0, 0, 12'h006, 32'h0);
    chk1("l1_fetch_drop", 0, 0, 0, 32'h77);
    step1(0, 1, 0, 12'h006, 32'h0);
    chk1("l1_reraise_accept", 0, 0, 1, 32'h77);
    step1(0, 1, 0, 12'h006, 32'h0);
    chk1("l1_reraise_ack", 1, 0, 1, 32'h88);
    step1(0, 0, 0, 12'h000, 32'h0);
    chk1("l1_idle", 0, 0, 0, 32'h88);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter: size, 4096, number of backing-store words.
REQ-002 Parameter: address_space, 12, address width in bits.
REQ-003 Parameter: data_size, 32, data width in bits.
REQ-004 Parameter: latency, 4, request-accept-to-ack delay in cycles; legal range 1..255.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clka  input  1  clock; all state changes on the rising edge.
REQ-007 rsta  input  1  synchronous reset, active-high.
REQ-008 fetch  input  1  read request from the cache, level, held until fetch_ack.
REQ-009 flush  input  1  write request from the cache, level, held until flush_ack.
REQ-010 addra  input  address_space  request word address.
REQ-011 dina  input  data_size  write data for flush.
REQ-012 douta  output  data_size  registered read data for fetch.
REQ-013 fetch_ack  output  1  registered fetch complete; douta valid while high.
REQ-014 flush_ack  output  1  registered flush complete; write committed.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, FETCH_WAIT, FLUSH_WAIT and ACK.
REQ-017 The backing store SHALL be size words of data_size bits, indexed by addra, with contents not cleared by reset.
REQ-018 In IDLE, at an edge with flush high, the block SHALL capture addra and dina, load the 8-bit counter with latency-1 and enter FLUSH_WAIT.
REQ-019 In IDLE, at an edge with fetch high and flush low, the block SHALL capture addra, load the counter with latency-1 and enter FETCH_WAIT.
REQ-020 When fetch and flush are high together in IDLE, flush SHALL win; fetch SHALL be served after the flush handshake completes.
REQ-021 In a WAIT state with counter nonzero, the counter SHALL decrement by 1 per edge; addra and dina changes SHALL be ignored (captured copies used).
REQ-022 In FETCH_WAIT with counter 0, the next edge SHALL load douta with mem[captured address], set fetch_ack to 1 and enter ACK.
REQ-023 In FLUSH_WAIT with counter 0, the next edge SHALL write captured data to mem[captured address], set flush_ack to 1 and enter ACK.
REQ-024 The ack SHALL therefore go high exactly latency edges after the accepting edge (latency=1: the edge after accept).
REQ-025 In ACK, the asserted ack and douta SHALL hold until an edge samples the corresponding request low; at that edge the ack SHALL clear and the state SHALL return to IDLE (four-phase handshake).
REQ-026 A new request SHALL NOT be accepted on the edge that leaves ACK; the earliest accept is the following edge.
REQ-027 If a request drops during WAIT, the transaction SHALL still complete; the ack SHALL pulse for one cycle and then clear.
REQ-028 fetch_ack and flush_ack SHALL never be high simultaneously.
REQ-029 douta SHALL change only on fetch completion or reset.
REQ-030 addra values at or above size SHALL be a don't-care (no protection).

Reset
REQ-031 At an edge with rsta high, the block SHALL enter IDLE and set douta=0, fetch_ack=0, flush_ack=0, busy=0 and counter=0, overriding all other activity.
REQ-032 Reset during a WAIT state SHALL abort the transaction with no memory write and no ack.
REQ-033 Reset during ACK SHALL clear the ack immediately; the memory write of a completed flush SHALL remain.

Verification
REQ-034 latency=4; flush addr 0x123, data 0xDEADBEEF accepted at edge 0 -> flush_ack=1 after edge 4; drop flush -> flush_ack=0 after the next edge; busy=0.
REQ-035 Follow-up fetch addr 0x123 -> fetch_ack=1 and douta=0xDEADBEEF after accept+4 edges; douta held until fetch drops.
REQ-036 fetch and flush both high in IDLE, addr 0x010, dina 0x5 -> flush_ack first; fetch then returns douta=0x5.
REQ-037 rsta pulsed at edge 2 of a flush to 0x200, data 0x1 -> no flush_ack; later fetch of 0x200 returns its prior value, not 0x1.
REQ-038 latency=1 fetch -> fetch_ack high after the edge following accept; addra changed during wait -> data from the captured address.
REQ-039 Request held high through ACK -> ack stays high with no re-accept; after the drop edge, re-raise fetch -> accepted one edge later.
